bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bin2bcd_seq_if.sv | 33 +++
 rtl/bin2bcd_dabble_slice.sv | 37 +++
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DECLEN_DEF / BINLEN_DEF / STEP_DEF : default digit count, input width, layers per cycle
//   state_e                            : controller states IDLE / BUSY / DONE
//   pow10()                            : 10**n as a 64-bit constant (n <= 19)
//   BCD_LIMIT                          : 10**DECLEN_DEF, first value that no longer fits
//   dabble_adj()                       : per-digit add-3 correction applied before each shift
package bcd_pkg;

  localparam int DECLEN_DEF = 9;
  localparam int BINLEN_DEF = 30;
  localparam int STEP_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] BCD_LIMIT = pow10(DECLEN_DEF);

  // A digit of 5..9 would become 10..18 after doubling; adding 3 first makes the
  // doubled value carry into the next nibble exactly when it reaches 10.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer/result consumer and bin2bcd_seq.
//   in_valid / in_ready   : operand handshake, BIN carries the unsigned operand
//   out_valid / out_ready : result handshake, BCD (digit 0 in [3:0]) and ovf carry the result
//   busy                  : converter is stepping through a conversion
// Modports: slave = converter side, master = producer/consumer side.
interface bin2bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BINLEN = BINLEN_DEF,
  parameter int DECLEN = DECLEN_DEF
)
();

  logic                  in_valid;
  logic                  in_ready;
  logic [BINLEN-1:0]     BIN;
  logic                  out_valid;
  logic                  out_ready;
  logic [DECLEN*4-1:0]   BCD;
  logic                  ovf;
  logic                  busy;

  modport slave (
    input  in_valid, BIN, out_ready,
    output in_ready, out_valid, BCD, ovf, busy
  );

  modport master (
    output in_valid, BIN, out_ready,
    input  in_ready, out_valid, BCD, ovf, busy
  );

endinterface

// File: rtl/bin2bcd_dabble_slice.sv
// Combinational double-dabble slice: applies STEP layers to the BCD accumulator.
//   acc_i : current accumulator, DECLEN packed digits
//   msb_i : next STEP binary bits, msb_i[STEP-1] is consumed first
//   acc_o : accumulator after STEP add-3/shift layers
// The carry out of the top digit is dropped, so the result is taken modulo 10**DECLEN.
module bin2bcd_dabble_slice
  import bcd_pkg::*;
#(
  parameter int DECLEN = DECLEN_DEF,
  parameter int STEP   = STEP_DEF
)
(
  input  logic [DECLEN*4-1:0] acc_i,
  input  logic [STEP-1:0]     msb_i,
  output logic [DECLEN*4-1:0] acc_o
);

  localparam int DW = DECLEN * 4;

  logic [DW-1:0] stage [STEP+1];

  assign stage[0] = acc_i;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_layer
    logic [DW-1:0] adj;

    for (genvar gd = 0; gd < DECLEN; gd++) begin : g_digit
      assign adj[gd*4 +: 4] = dabble_adj(stage[gi][gd*4 +: 4]);
    end

    // Shift left by one, new binary bit enters at bit 0; the cast drops the top carry.
    assign stage[gi+1] = DW'({adj, msb_i[STEP-1-gi]});
  end

  assign acc_o = stage[STEP];

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, STEP dabble layers per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin2bcd_seq_if.slave -- operand in (in_valid/in_ready/BIN),
//           result out (out_valid/out_ready/BCD/ovf), busy status
// A load in IDLE is followed by BINLEN/STEP cycles in BUSY, then the result is
// held in DONE until the consumer takes it.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int DECLEN = DECLEN_DEF,
  parameter int BINLEN = BINLEN_DEF,
  parameter int STEP   = STEP_DEF
)
(
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int NSTEPS = BINLEN / STEP;
  localparam int CNTW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NSTEPS - 1);
  localparam int DW     = DECLEN * 4;

  // Compare at a width covering both the operand and the 64-bit limit; when the
  // limit exceeds every representable operand the compare is constant 0.
  localparam int CW = ((BINLEN > 64) ? BINLEN : 64) + 1;
  localparam logic [63:0]   LIMIT   = (DECLEN == DECLEN_DEF) ? BCD_LIMIT : pow10(DECLEN);
  localparam logic [CW-1:0] LIMIT_X = CW'(LIMIT);

  if (BINLEN % STEP != 0) begin : g_step_check
    $error("bin2bcd_seq: BINLEN must be a multiple of STEP");
  end

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [BINLEN-1:0]   sr_q, sr_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic                ovf_q, ovf_d;

  logic [DW-1:0]       acc_step;
  logic [CW-1:0]       bin_x;
  logic                ovf_load;

  bin2bcd_dabble_slice #(
    .DECLEN (DECLEN),
    .STEP   (STEP)
  ) u_slice (
    .acc_i  (acc_q),
    .msb_i  (sr_q[BINLEN-1 -: STEP]),
    .acc_o  (acc_step)
  );

  assign bin_x    = CW'(bus.BIN);
  assign ovf_load = (bin_x >= LIMIT_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.BIN;
          acc_d   = '0;
          ovf_d   = ovf_load;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        sr_d  = sr_q << STEP;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_valid = (state_q == DONE);
  assign bus.BCD       = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed conversions on a STEP=1 instance, then a
// randomised back-to-back stream with random backpressure on a STEP=3 instance.
module tb_bin2bcd_seq;

  localparam int BINLEN = 30;
  localparam int DECLEN = 9;
  localparam int N_RAND = 2000;

  logic clk    = 1'b0;
  logic rst1_n = 1'b0;
  logic rst3_n = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BINLEN(BINLEN), .DECLEN(DECLEN)) if1 ();
  bin2bcd_seq_if #(.BINLEN(BINLEN), .DECLEN(DECLEN)) if3 ();

  bin2bcd_seq #(.DECLEN(DECLEN), .BINLEN(BINLEN), .STEP(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (if1)
  );

  bin2bcd_seq #(.DECLEN(DECLEN), .BINLEN(BINLEN), .STEP(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (if3)
  );

  int checks = 0;
  int errors = 0;

  // Expected result: {ovf, 36-bit BCD}
  logic [36:0] sb1 [$];

  typedef struct {
    logic [36:0] exp;
    int          stamp;
  } sb3_t;
  sb3_t sb3 [$];

  int          r_sent, r_got, r_cyc, n;
  logic        offering, seen;
  logic [29:0] r_bin;
  logic [36:0] e;
  sb3_t        s;

  function automatic logic [36:0] ref_conv(input logic [29:0] b);
    longint unsigned v;
    logic [35:0] d;
    v = longint'(b) % 64'd1000000000;
    d = '0;
    for (int i = 0; i < 9; i++) begin
      d[i*4 +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return {(b >= 30'd1000000000), d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion on the STEP=1 instance with out_ready already high.
  task automatic do_conv1(input logic [29:0] b);
    int cnt;
    logic [36:0] x;
    cnt = 0;
    while (!if1.in_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("conv_in_ready", 64'(if1.in_ready), 64'd1);
    if1.BIN      = b;
    if1.in_valid = 1'b1;
    sb1.push_back(ref_conv(b));
    tick();                               // acceptance edge
    if1.in_valid = 1'b0;
    chk("conv_busy", 64'(if1.busy), 64'd1);
    chk("conv_in_ready_low", 64'(if1.in_ready), 64'd0);
    cnt = 0;
    while (!if1.out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    // out_valid rises on the 30th edge after acceptance (31st cycle counting the accept cycle)
    chk("conv_latency", 64'(cnt), 64'd30);
    x = sb1.pop_front();
    chk("conv_bcd", 64'(if1.BCD), 64'(x[35:0]));
    chk("conv_ovf", 64'(if1.ovf), 64'(x[36]));
    tick();                               // result taken
    chk("conv_back_idle", 64'(if1.in_ready), 64'd1);
    chk("conv_valid_drop", 64'(if1.out_valid), 64'd0);
  endtask

  initial begin
    if1.in_valid  = 1'b0;
    if1.BIN       = '0;
    if1.out_ready = 1'b0;
    if3.in_valid  = 1'b0;
    if3.BIN       = '0;
    if3.out_ready = 1'b0;

    // Reset values while held in reset
    repeat (3) tick();
    chk("rst_in_ready", 64'(if1.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst_busy", 64'(if1.busy), 64'd0);
    chk("rst_bcd", 64'(if1.BCD), 64'd0);
    chk("rst_ovf", 64'(if1.ovf), 64'd0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    tick();

    // Directed conversions, consumer always ready
    if1.out_ready = 1'b1;
    do_conv1(30'd0);
    do_conv1(30'd999999999);
    do_conv1(30'd1000000000);
    do_conv1(30'h3FFFFFFF);

    // Backpressure: result held while out_ready low, input offers ignored
    if1.out_ready = 1'b0;
    if1.BIN       = 30'd255;
    if1.in_valid  = 1'b1;
    sb1.push_back(ref_conv(30'd255));
    tick();
    if1.in_valid = 1'b0;
    n = 0;
    while (!if1.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd30);
    e = sb1.pop_front();
    chk("bp_bcd_first", 64'(if1.BCD), 64'(e[35:0]));
    for (int i = 0; i < 10; i++) begin
      if1.in_valid = i[0];
      if1.BIN      = 30'd7;
      tick();
      chk("bp_valid_hold", 64'(if1.out_valid), 64'd1);
      chk("bp_bcd_hold", 64'(if1.BCD), 64'(e[35:0]));
      chk("bp_in_ready", 64'(if1.in_ready), 64'd0);
    end
    if1.in_valid  = 1'b0;
    if1.out_ready = 1'b1;
    tick();
    chk("bp_release_idle", 64'(if1.in_ready), 64'd1);
    chk("bp_release_valid", 64'(if1.out_valid), 64'd0);
    do_conv1(30'd7);

    // Reset in the 12th BUSY cycle
    if1.BIN      = 30'd12345;
    if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("mid_busy", 64'(if1.busy), 64'd1);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(if1.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(if1.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(if1.busy), 64'd0);
    chk("mid_rst_bcd", 64'(if1.BCD), 64'd0);
    chk("mid_rst_ovf", 64'(if1.ovf), 64'd0);
    tick();
    rst1_n = 1'b1;
    do_conv1(30'd42);

    // STEP=3: back-to-back random operands, random out_ready.
    // Everything is driven/observed at the falling edge; values set here are
    // what the following rising edge samples.
    r_sent   = 0;
    r_got    = 0;
    r_cyc    = 0;
    offering = 1'b0;
    seen     = 1'b0;
    while (r_got < N_RAND && r_cyc < 60000) begin
      @(negedge clk);
      r_cyc++;
      // Accepted just after negedge "stamp", out_valid first visible 11 negedges later
      if (if3.out_valid && !seen) begin
        seen = 1'b1;
        if (sb3.size() == 0) begin
          chk("rand_unexpected_result", 64'd1, 64'd0);
        end else begin
          chk("rand_latency", 64'(r_cyc - sb3[0].stamp), 64'd11);
        end
      end
      if3.out_ready = 1'($urandom_range(0, 1));
      if (!offering) begin
        if (r_sent < N_RAND) begin
          r_bin = ($urandom_range(0, 1) == 1) ? 30'($urandom_range(0, 999999999))
                                              : 30'($urandom);
          if3.BIN      = r_bin;
          if3.in_valid = 1'b1;
          offering     = 1'b1;
        end else begin
          if3.in_valid = 1'b0;
        end
      end
      if (if3.in_valid && if3.in_ready && offering) begin
        s.exp   = ref_conv(if3.BIN);
        s.stamp = r_cyc;
        sb3.push_back(s);
        r_sent++;
        offering = 1'b0;
      end
      if (if3.out_valid && if3.out_ready) begin
        if (sb3.size() == 0) begin
          chk("rand_extra_result", 64'd1, 64'd0);
        end else begin
          s = sb3.pop_front();
          chk("rand_bcd", 64'(if3.BCD), 64'(s.exp[35:0]));
          chk("rand_ovf", 64'(if3.ovf), 64'(s.exp[36]));
        end
        r_got++;
        seen = 1'b0;
      end
    end
    if3.in_valid = 1'b0;
    chk("rand_sent", 64'(r_sent), 64'(N_RAND));
    chk("rand_received", 64'(r_got), 64'(N_RAND));
    chk("rand_leftover", 64'(sb3.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
